div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential 32-bit signed integer divider for the multicycle MIPS datapath; implements DIV.
- Consumes operands from registers A (dividend) and B (divisor).
- Produces the remainder for the HI source mux and the quotient for the LO source mux.
- Sits alongside the multiplier; control starts it, waits for done, then pulses WriteHI/WriteLO and raises the divide-by-zero exception on div_zero.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  dividend (RegAOut).
- b_in  input  WIDTH  divisor (RegBOut).
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse, coincident with done, when the divisor was 0.
- counter  output  CNT_W  current iteration index, for debug/waveforms.
- hi_out  output  WIDTH  remainder (to MuxHICtrl).
- lo_out  output  WIDTH  quotient (to MuxLOCtrl).

Behaviour:
- Reset: one clock, reset asynchronous and active-low. Reset low forces state IDLE and clears busy, done, div_zero, counter, hi_out, lo_out and all internal registers to 0, immediately and regardless of clock. Reset mid-operation abandons the division; no done pulse follows.
- States:
  - IDLE: busy=0.
    - start=1, b_in != 0 -> latch |a_in|, |b_in|, sign_q = a_in[31]^b_in[31], sign_r = a_in[31]; clear partial remainder and counter; go to RUN.
    - start=1, b_in == 0 -> go to ZERO.
  - RUN: busy=1. One restoring-division step per cycle: shift {rem, quo} left 1, trial subtract divisor, keep result if non-negative, set quotient bit. Counter increments every cycle; after WIDTH steps (counter == WIDTH-1 at the edge) go to FIX.
  - FIX: busy=1. Negate quotient if sign_q, negate remainder if sign_r. Register into lo_out/hi_out. Go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. Go to IDLE.
  - ZERO: done=1, div_zero=1 for exactly one cycle. hi_out/lo_out keep their previous values. Go to IDLE.
- Latency:
  - Nonzero divisor: done is high in the cycle that starts WIDTH+2 rising edges after the edge sampling start (34 for WIDTH=32).
  - Zero divisor: done/div_zero are high in the cycle after the sampling edge.
- Start handling:
  - start while busy or in DONE/ZERO is ignored; it is not queued.
  - Operands are captured only at the sampling edge; later changes on a_in/b_in have no effect.
- Output hold: hi_out/lo_out are registered and hold their value until the next FIX; they are valid from the done cycle onward.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - |x| of 0x80000000 is handled as unsigned 0x80000000, so the datapath uses a WIDTH+1-bit trial subtract.
  - 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0. This is wrap-around, with no flag.
- counter reads 0 outside RUN.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When 1 (DIVU), the operands are treated as unsigned: no absolute value and no sign fix. FIX still occupies its cycle, so latency is unchanged.
  - Division by zero behaves identically.
- Undefined: port absent; all divisions are signed.

Test Plan:
- a=100, b=7, start 1 cycle -> busy for 33 cycles; done at edge +34; lo_out=14, hi_out=2; div_zero=0.
- a=0xFFFFFF9C (-100), b=7 -> lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2).
- Preload hi/lo with 100/7, then a=7, b=0 -> next cycle done=1 and div_zero=1 for one cycle; hi_out=2, lo_out=14 unchanged; busy never 1.
- a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0; then a=0x80000000, b=2 -> lo_out=0xC0000000, hi_out=0.
- Start 100/7, pulse start with a=9, b=3 at cycle 5, then assert reset low at cycle 10 (counter=9) -> outputs immediately 0; no done; a subsequent 9/3 gives lo_out=3, hi_out=0.
- With DIV_UNSIGNED_EN, is_unsigned=1, a=0xFFFFFFFF, b=2 -> lo_out=0x7FFFFFFF, hi_out=1; the same operands with is_unsigned=0 -> lo_out=0, hi_out=0xFFFFFFFF.

Source files
------------

// File: rtl/div_unit_if.sv
// Operand/result bundle between the multicycle control and the divider.
// The is_unsigned lane exists only when DIV_UNSIGNED_EN is defined.
interface div_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  // Handshake: start is sampled only while the divider is idle; busy is high
  // during the division, and done pulses for exactly one cycle when the result
  // (or a divide-by-zero, flagged by div_zero) is available. Starts seen while
  // busy or completing are dropped, not queued.
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             start;
`ifdef DIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [2:0]       dbgState;

  modport master (
`ifdef DIV_UNSIGNED_EN
    output is_unsigned,
`endif
    output a_in, b_in, start,
    input  busy, done, div_zero, counter, hi_out, lo_out, dbgState
  );

  modport slave (
`ifdef DIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    input  a_in, b_in, start,
    output busy, done, div_zero, counter, hi_out, lo_out, dbgState
  );
endinterface

// File: rtl/div_unit.sv
// Sequential restoring divider for DIV: quotient to LO, remainder to HI.
// Define DIV_UNSIGNED_EN to add the is_unsigned (DIVU) operand mode.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clock,
  input logic       reset,
  div_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } divStateT;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divStateT         state;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisor;
  logic             signQ;
  logic             signR;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             busyReg;
  logic             doneReg;
  logic             zeroReg;

  logic             opSigned;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             stepOk;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;

`ifdef DIV_UNSIGNED_EN
  assign opSigned = !bus.is_unsigned;
`else
  assign opSigned = 1'b1;
`endif

  // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign absA = (opSigned && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign absB = (opSigned && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;

  always_comb begin
    shifted = {remReg, quoReg[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    // The partial remainder stays below the divisor, so an accepted trial
    // always leaves both top bits clear; any set bit means the step failed.
    stepOk  = (trial[WIDTH+1:WIDTH] == 2'b00);
    stepRem = stepOk ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    stepQuo = {quoReg[WIDTH-2:0], stepOk};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      remReg  <= '0;
      quoReg  <= '0;
      divisor <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      cnt     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      zeroReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busyReg <= 1'b0;
          doneReg <= 1'b0;
          zeroReg <= 1'b0;
          cnt     <= '0;
          if (bus.start) begin
            if (bus.b_in != '0) begin
              divisor <= absB;
              quoReg  <= absA;
              remReg  <= '0;
              signQ   <= opSigned && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
              signR   <= opSigned && bus.a_in[WIDTH-1];
              state   <= RUN;
            end else begin
              // Divide-by-zero reports in the very next cycle and leaves HI/LO alone.
              doneReg <= 1'b1;
              zeroReg <= 1'b1;
              state   <= ZERO;
            end
          end
        end
        RUN: begin
          busyReg <= 1'b1;
          remReg  <= stepRem;
          quoReg  <= stepQuo;
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          busyReg <= 1'b1;
          loReg   <= signQ ? -quoReg : quoReg;
          hiReg   <= signR ? -remReg : remReg;
          state   <= DONE;
        end
        DONE: begin
          busyReg <= 1'b0;
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        ZERO: begin
          doneReg <= 1'b0;
          zeroReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign bus.div_zero = zeroReg;
  assign bus.counter  = cnt;
  assign bus.hi_out   = hiReg;
  assign bus.lo_out   = loReg;
  assign bus.dbgState = state;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, hand-written multi-cycle
// sequences (ignored start, async reset mid-division) and random operands.
module tb_div_unit;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  div_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  int tests = 0;
  int failures = 0;
  logic [2*WIDTH:0] exp_q[$];
  logic [2*WIDTH:0] mon_e;
  logic [WIDTH-1:0] last_lo = '0;
  logic [WIDTH-1:0] last_hi = '0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: 64-bit integer division truncates toward zero and the
  // remainder follows the dividend, which is the DIV/DIVU contract.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    logic [63:0] qb, rb;
    if (b == 32'd0) begin
      lo = last_lo;
      hi = last_hi;
      return;
    end
    sa = uns ? {32'd0, a} : {{32{a[31]}}, a};
    sb = uns ? {32'd0, b} : {{32{b[31]}}, b};
    q = sa / sb;
    r = sa % sb;
    qb = q;
    rb = r;
    lo = qb[31:0];
    hi = rb[31:0];
  endfunction

  // Scoreboard: every done pulse consumes one expected {div_zero, hi, lo}.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious done", bus.done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("lo_out", bus.lo_out, mon_e[WIDTH-1:0]);
        check("hi_out", bus.hi_out, mon_e[2*WIDTH-1:WIDTH]);
        check("div_zero", bus.div_zero, mon_e[2*WIDTH]);
      end
    end
  end

  // Drives one start pulse from a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic uns,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    bus.a_in = a;
    bus.b_in = b;
    bus.start = 1'b1;
`ifdef DIV_UNSIGNED_EN
    bus.is_unsigned = uns;
`endif
    exp_q.push_back({(b == 32'd0), exp_hi, exp_lo});
    last_lo = exp_lo;
    last_hi = exp_hi;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
  endtask

  // Counts rising edges from the sampling edge until done, bounded.
  task automatic await_done(input string name, input logic zero, input int start_edge,
                            input logic check_busy);
    int edges;
    int busy_cnt;
    edges = start_edge;
    busy_cnt = 0;
    while (!bus.done && edges < 120) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    check({name, " latency"}, edges, zero ? 0 : WIDTH + 2);
    if (check_busy) check({name, " busy cycles"}, busy_cnt, zero ? 0 : WIDTH + 1);
    if (!bus.done && exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    check({name, " done width"}, bus.done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, elo, ehi;
    logic        ru;
    logic        done_seen;
    int          sel;

    bus.a_in = '0;
    bus.b_in = '0;
    bus.start = 1'b0;
`ifdef DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif

    vecs.push_back('{32'hFFFFFF9C, 32'd7,         1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE});
    vecs.push_back('{32'd100,      32'd7,         1'b0, 32'd14,       32'd2});
    vecs.push_back('{32'd7,        32'd0,         1'b0, 32'd14,       32'd2});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF,  1'b0, 32'h80000000, 32'd0});
    vecs.push_back('{32'h80000000, 32'd2,         1'b0, 32'hC0000000, 32'd0});
    vecs.push_back('{32'd100,      32'hFFFFFFF9,  1'b0, 32'hFFFFFFF2, 32'd2});
    vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9,  1'b0, 32'd14,       32'hFFFFFFFE});
    vecs.push_back('{32'd5,        32'd10,        1'b0, 32'd0,        32'd5});
    vecs.push_back('{32'd0,        32'd5,         1'b0, 32'd0,        32'd0});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000,  1'b0, 32'd0,        32'hFFFFFFFF});
    vecs.push_back('{32'h7FFFFFFF, 32'd1,         1'b0, 32'h7FFFFFFF, 32'd0});
    vecs.push_back('{32'h80000000, 32'h80000000,  1'b0, 32'd1,        32'd0});
`ifdef DIV_UNSIGNED_EN
    vecs.push_back('{32'hFFFFFFFF, 32'd2,         1'b1, 32'h7FFFFFFF, 32'd1});
    vecs.push_back('{32'hFFFFFFFF, 32'd2,         1'b0, 32'd0,        32'hFFFFFFFF});
    vecs.push_back('{32'd9,        32'd0,         1'b1, 32'd0,        32'hFFFFFFFF});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset hi_out", bus.hi_out, 0);
    check("reset lo_out", bus.lo_out, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset div_zero", bus.div_zero, 0);
    check("reset counter", bus.counter, 0);
    check("reset state", bus.dbgState, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].uns, vecs[i].lo, vecs[i].hi);
      await_done($sformatf("vec%0d", i), vecs[i].b == 32'd0, 0, 1'b1);
    end

    // A start pulse while busy must be dropped, not queued.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (4) @(negedge clk);
    bus.a_in = 32'd9;
    bus.b_in = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    await_done("ignored start", 1'b0, 5, 1'b0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a division.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (4) @(negedge clk);
    bus.a_in = 32'd9;
    bus.b_in = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid counter", bus.counter, 9);
    check("mid busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async hi_out", bus.hi_out, 0);
    check("async lo_out", bus.lo_out, 0);
    check("async counter", bus.counter, 0);
    check("async busy", bus.busy, 0);
    check("async state", bus.dbgState, 0);
    exp_q.delete();
    last_lo = '0;
    last_hi = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_seen |= bus.done;
    end
    check("no done after reset", done_seen, 0);
    issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    await_done("post reset", 1'b0, 0, 1'b1);

    // Random operands, including zero and small/negative divisors.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
`ifdef DIV_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      model(ra, rb, ru, elo, ehi);
      issue(ra, rb, ru, elo, ehi);
      await_done($sformatf("rand%0d", i), rb == 32'd0, 0, 1'b1);
    end

    repeat (5) @(negedge clk);
    check("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
